fan_1to32: RTL and testbench

FAN_1TO32 -- requirements
Module: fan_1to32

---
 rtl/fan_1to32_pkg.sv | 19 +
 rtl/fan_shift32.sv | 65 ++++++
 rtl/fan_1to32.sv | 87 ++++++++
 tb/tb_fan_1to32.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fan_1to32_pkg.sv
// rtl/fan_1to32_pkg.sv - shared constants, state type and bit placement helper for fan_1to32
package fan_1to32_pkg;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 5;

    localparam logic [CNT_W-1:0] CNT_LAST = 5'd31;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_STALL   = 1'b1
    } fan_state_t;

    // Word position of the serial bit with index pos within the frame.
    function automatic logic [CNT_W-1:0] bit_pos(input logic [CNT_W-1:0] pos, input logic lsb_first);
        return lsb_first ? pos : (CNT_LAST - pos);
    endfunction

endpackage

// File: rtl/fan_shift32.sv
// rtl/fan_shift32.sv - serial-to-parallel shift register with 5-bit bit counter
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   i_accept      a serial bit is taken this cycle
//   i_din         serial bit
//   i_sof         start of frame for the bit being taken
//   o_word        shift register contents with this cycle's bit merged in
//   o_cnt_next    counter value after this cycle
//   o_done        the bit taken this cycle completes a word (o_word is final)
//   o_restart     the bit taken this cycle discarded a partial word
module fan_shift32
    import fan_1to32_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_accept,
    input  logic              i_din,
    input  logic              i_sof,
    output logic [WORD_W-1:0] o_word,
    output logic [CNT_W-1:0]  o_cnt_next,
    output logic              o_done,
    output logic              o_restart
);

    logic [WORD_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_restart;
    logic [CNT_W-1:0]  w_pos;
    logic [WORD_W-1:0] w_word;

    // A start-of-frame bit on a non-empty register restarts the frame at position 0.
    assign w_restart = i_sof && (r_cnt != '0);
    assign w_pos     = w_restart ? '0 : r_cnt;

    always_comb begin
        w_word = w_restart ? '0 : r_shift;
        w_word[bit_pos(w_pos, LSB_FIRST)] = i_din;
    end

    assign o_word    = w_word;
    assign o_done    = i_accept && (w_pos == CNT_LAST);
    assign o_restart = i_accept && w_restart;

    always_comb begin
        o_cnt_next = r_cnt;
        if (i_accept) begin
            o_cnt_next = (w_pos == CNT_LAST) ? '0 : (w_pos + 1'b1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_accept) begin
            r_cnt   <= o_cnt_next;
            r_shift <= o_done ? '0 : w_word;
        end
    end

endmodule

// File: rtl/fan_1to32.sv
// rtl/fan_1to32.sv - 1-bit serial to 32-bit parallel word assembler with backpressure
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   din, din_valid, din_sof       serial input bit, its valid, start-of-frame marker
//   din_ready                     serial bit accepted this cycle
//   a32, a32_valid, a32_ready     parallel output word handshake
//   drop                          one-cycle pulse when a partial word was discarded
module fan_1to32
    import fan_1to32_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    input  logic              din_valid,
    input  logic              din_sof,
    output logic              din_ready,
    output logic [WORD_W-1:0] a32,
    output logic              a32_valid,
    input  logic              a32_ready,
    output logic              drop
);

    fan_state_t        r_state;
    fan_state_t        w_state_next;
    logic [WORD_W-1:0] r_a32;
    logic              r_valid;
    logic              r_drop;

    logic              w_accept;
    logic              w_valid_next;
    logic [WORD_W-1:0] w_word;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_done;
    logic              w_restart;

    // STALL means 31 bits are held and the output word is pending. A word leaving
    // this cycle frees the output register, so the 32nd bit can still be taken then.
    assign din_ready = (r_state == ST_COLLECT) || a32_ready;
    assign w_accept  = din_valid && din_ready;

    fan_shift32 #(
        .LSB_FIRST (LSB_FIRST)
    ) u_shift (
        .clk        (clk),
        .rst        (rst),
        .i_accept   (w_accept),
        .i_din      (din),
        .i_sof      (din_sof),
        .o_word     (w_word),
        .o_cnt_next (w_cnt_next),
        .o_done     (w_done),
        .o_restart  (w_restart)
    );

    assign w_valid_next = w_done || (r_valid && !a32_ready);

    always_comb begin
        w_state_next = ST_COLLECT;
        if ((w_cnt_next == CNT_LAST) && w_valid_next) begin
            w_state_next = ST_STALL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_COLLECT;
            r_a32   <= '0;
            r_valid <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_valid <= w_valid_next;
            r_drop  <= w_restart;
            if (w_done) begin
                r_a32 <= w_word;
            end
        end
    end

    assign a32       = r_a32;
    assign a32_valid = r_valid;
    assign drop      = r_drop;

endmodule

// File: tb/tb_fan_1to32.sv
// tb/tb_fan_1to32.sv - self-checking bench for fan_1to32 against a queue-based reference model
module tb_fan_1to32;

    logic        clk;
    logic        rst;
    logic        din;
    logic        din_valid;
    logic        din_sof;
    logic        a32_ready;

    logic        din_ready_l, a32_valid_l, drop_l;
    logic [31:0] a32_l;
    logic        din_ready_m, a32_valid_m, drop_m;
    logic [31:0] a32_m;

    fan_1to32 #(.LSB_FIRST(1'b1)) dut_l (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_sof   (din_sof),
        .din_ready (din_ready_l),
        .a32       (a32_l),
        .a32_valid (a32_valid_l),
        .a32_ready (a32_ready),
        .drop      (drop_l)
    );

    fan_1to32 #(.LSB_FIRST(1'b0)) dut_m (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_sof   (din_sof),
        .din_ready (din_ready_m),
        .a32       (a32_m),
        .a32_valid (a32_valid_m),
        .a32_ready (a32_ready),
        .drop      (drop_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    bit          m_bits[$];
    logic        m_valid;
    logic [31:0] m_word_l;
    logic [31:0] m_word_m;
    logic        m_drop;

    int          n_checks;
    int          n_fail;
    int          drop_seen;
    logic        last_acc;
    logic [31:0] rx_words[$];

    // One clock cycle: drive inputs at the falling edge, check outputs 1 ns later,
    // then advance the model at the rising edge.
    task automatic cycle(input logic r, input logic d, input logic v, input logic s, input logic rdy);
        logic exp_ready;
        logic xfer;
        rst = r; din = d; din_valid = v; din_sof = s; a32_ready = rdy;
        #1;
        exp_ready = !((m_bits.size() == 31) && m_valid && !rdy);
        n_checks++;
        if (din_ready_l !== exp_ready) begin
            n_fail++; $display("FAIL din_ready_l: got %b expected %b", din_ready_l, exp_ready);
        end
        n_checks++;
        if (din_ready_m !== exp_ready) begin
            n_fail++; $display("FAIL din_ready_m: got %b expected %b", din_ready_m, exp_ready);
        end
        n_checks++;
        if (a32_valid_l !== m_valid || a32_valid_m !== m_valid) begin
            n_fail++; $display("FAIL a32_valid: got %b/%b expected %b", a32_valid_l, a32_valid_m, m_valid);
        end
        n_checks++;
        if (a32_l !== m_word_l) begin
            n_fail++; $display("FAIL a32_l: got %h expected %h", a32_l, m_word_l);
        end
        n_checks++;
        if (a32_m !== m_word_m) begin
            n_fail++; $display("FAIL a32_m: got %h expected %h", a32_m, m_word_m);
        end
        n_checks++;
        if (drop_l !== m_drop || drop_m !== m_drop) begin
            n_fail++; $display("FAIL drop: got %b/%b expected %b", drop_l, drop_m, m_drop);
        end
        if (drop_l === 1'b1) drop_seen++;
        if (!r && a32_valid_l && rdy) rx_words.push_back(a32_l);
        last_acc = !r && v && exp_ready;

        @(posedge clk);
        if (r) begin
            m_bits.delete();
            m_valid  = 1'b0;
            m_word_l = '0;
            m_word_m = '0;
            m_drop   = 1'b0;
        end else begin
            xfer   = m_valid && rdy;
            m_drop = 1'b0;
            if (last_acc) begin
                if (s && m_bits.size() != 0) begin
                    m_bits.delete();
                    m_drop = 1'b1;
                end
                m_bits.push_back(d);
            end
            if (m_bits.size() == 32) begin
                for (int i = 0; i < 32; i++) begin
                    m_word_l[i]    = m_bits[i];
                    m_word_m[31-i] = m_bits[i];
                end
                m_valid = 1'b1;
                m_bits.delete();
            end else if (xfer) begin
                m_valid = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input logic rdy);
        for (int i = 0; i < 32; i++) begin
            int tries = 0;
            do begin
                cycle(1'b0, w[i], 1'b1, 1'b0, rdy);
                tries++;
            end while (!last_acc && tries < 8);
            if (!last_acc) begin
                n_checks++; n_fail++;
                $display("FAIL send_word_timeout: got not-accepted expected accepted at bit %0d", i);
            end
        end
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (a32_l !== 32'h0 || a32_valid_l !== 1'b0 || drop_l !== 1'b0 || din_ready_l !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: got a32=%h v=%b drop=%b rdy=%b expected 0/0/0/1",
                     a32_l, a32_valid_l, drop_l, din_ready_l);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_lsb_word();
        int vcount;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        send_word(32'hA5A5F00F, 1'b1);
        n_checks++;
        if (a32_l !== 32'hA5A5F00F || a32_valid_l !== 1'b1) begin
            n_fail++; $display("FAIL lsb_word: got %h v=%b expected a5a5f00f v=1", a32_l, a32_valid_l);
        end
        vcount = 0;
        for (int i = 0; i < 3; i++) begin
            if (a32_valid_l) vcount++;
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        n_checks++;
        if (vcount != 1) begin
            n_fail++; $display("FAIL lsb_valid_cycles: got %0d expected 1", vcount);
        end
    endtask

    task automatic test_msb_word();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        send_word(32'h80000001, 1'b1);
        n_checks++;
        if (a32_m !== 32'h80000001) begin
            n_fail++; $display("FAIL msb_word: got %h expected 80000001", a32_m);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_backpressure();
        logic [31:0] w1, w2;
        logic [63:0] stream;
        int idx, stall, first_stall_at, cyc;
        w1 = $urandom; w2 = $urandom;
        stream = {w2, w1};
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        rx_words.delete();
        idx = 0; stall = 0; first_stall_at = -1; cyc = 0;
        while (idx < 64 && cyc < 200) begin
            cycle(1'b0, stream[idx], 1'b1, 1'b0, stall >= 3);
            if (last_acc) idx++;
            else begin
                if (first_stall_at < 0) first_stall_at = idx;
                stall++;
            end
            cyc++;
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (first_stall_at != 63) begin
            n_fail++; $display("FAIL bp_stall_point: got %0d expected 63", first_stall_at);
        end
        n_checks++;
        if (rx_words.size() != 2) begin
            n_fail++; $display("FAIL bp_word_count: got %0d expected 2", rx_words.size());
        end else begin
            n_checks++;
            if (rx_words[0] !== w1 || rx_words[1] !== w2) begin
                n_fail++;
                $display("FAIL bp_word_order: got %h %h expected %h %h", rx_words[0], rx_words[1], w1, w2);
            end
        end
    endtask

    task automatic test_sof_drop();
        int d0;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        d0 = drop_seen;
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'($urandom), 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 31; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (a32_l !== 32'h00000001 || a32_m !== 32'h80000000) begin
            n_fail++; $display("FAIL sof_word: got %h/%h expected 00000001/80000000", a32_l, a32_m);
        end
        n_checks++;
        if (drop_seen - d0 != 1) begin
            n_fail++; $display("FAIL sof_drop_count: got %0d expected 1", drop_seen - d0);
        end
        // start-of-frame on an empty register is an ordinary bit
        d0 = drop_seen;
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (drop_seen != d0) begin
            n_fail++; $display("FAIL sof_empty_drop: got %0d expected 0", drop_seen - d0);
        end
    endtask

    task automatic test_reset_midword();
        int d0;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        d0 = drop_seen;
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'($urandom), 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        send_word(32'hFFFFFFFF, 1'b1);
        n_checks++;
        if (a32_l !== 32'hFFFFFFFF || a32_valid_l !== 1'b1) begin
            n_fail++; $display("FAIL rst_midword_word: got %h v=%b expected ffffffff v=1", a32_l, a32_valid_l);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (drop_seen != d0) begin
            n_fail++; $display("FAIL rst_midword_drop: got %0d expected 0", drop_seen - d0);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] wa, wb;
        wa = $urandom; wb = $urandom;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 32; i++) cycle(1'b0, wa[i], 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 31; i++) cycle(1'b0, wb[i], 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (a32_l !== wa || din_ready_l !== 1'b0) begin
            n_fail++; $display("FAIL b2b_held: got %h rdy=%b expected %h rdy=0", a32_l, din_ready_l, wa);
        end
        cycle(1'b0, wb[31], 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (a32_valid_l !== 1'b1 || a32_l !== wb) begin
            n_fail++; $display("FAIL b2b_next: got %h v=%b expected %h v=1", a32_l, a32_valid_l, wb);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom % 200) == 0, 1'($urandom), ($urandom % 4) != 0,
                  ($urandom % 24) == 0, ($urandom % 3) != 0);
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0; drop_seen = 0; last_acc = 1'b0;
        m_valid = 1'b0; m_word_l = '0; m_word_m = '0; m_drop = 1'b0;
        rst = 1'b1; din = 1'b0; din_valid = 1'b0; din_sof = 1'b0; a32_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        test_reset();
        test_lsb_word();
        test_msb_word();
        test_backpressure();
        test_sof_drop();
        test_reset_midword();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
